// File: rtl/datamemory_ctrl.sv
// datamemory_ctrl: byte-addressable little-endian data memory behind a small
// request/response FSM (IDLE -> BEAT0 [-> BEAT1] -> RESP).
// Build macro DMEM_MISALIGN_SPLIT_EN: when defined, an access that crosses a
// word boundary is split over two beats; when undefined, any misaligned
// access is rejected with err=1 and BEAT1 is never entered.
module datamemory_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic                  req_ready,
    output logic [DATA_W-1:0]     rd,
    output logic                  rsp_valid,
    output logic                  err
);
    localparam int NB    = DATA_W / 8;
    localparam int NB2   = 2 * NB;
    localparam int LB    = $clog2(NB);
    localparam int WA    = DM_ADDRESS - LB;
    localparam int DEPTH = 2 ** WA;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t                state_reg;
    logic [DM_ADDRESS-1:0] addr_reg;
    logic [DATA_W-1:0]     wd_reg;
    logic [2:0]            f3_reg;
    logic                  store_reg;
    logic [DATA_W-1:0]     lo_word_reg;
    logic [DATA_W-1:0]     rdata_reg;
    logic [DATA_W-1:0]     rd_reg;
    logic                  rsp_valid_reg;
    logic                  err_reg;

    logic [DATA_W-1:0]     mem [DEPTH];

    // Decode of the latched request
    logic [WA-1:0]         word_addr;
    logic [WA-1:0]         next_word;
    logic [LB-1:0]         off;
    logic [3:0]            size_bytes;
    logic                  legal;
    logic                  misaligned;
    logic                  spans;
    logic                  split;
    logic                  fault;
    logic [NB2-1:0]        lane_base;
    logic [NB2-1:0]        lane_mask;
    logic [DATA_W-1:0]     value_mask;
    logic [2*DATA_W-1:0]   wd_shifted;
    logic [2*DATA_W-1:0]   window_src;
    logic [2*DATA_W-1:0]   window_shifted;
    logic [DATA_W-1:0]     load_raw;
    logic                  sign_bit;
    logic [DATA_W-1:0]     load_value;

    // RAM port signals
    logic [NB-1:0]         mem_we;
    logic [WA-1:0]         mem_waddr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [WA-1:0]         mem_raddr;

    assign word_addr  = addr_reg[DM_ADDRESS-1:LB];
    assign next_word  = word_addr + WA'(1);    // wraps past the top word to word 0
    assign off        = addr_reg[LB-1:0];
    assign size_bytes = 4'd1 << f3_reg[1:0];
    assign misaligned = |(off & LB'(size_bytes - 4'd1));
    assign spans      = (int'(off) + int'(size_bytes)) > NB;
    assign split      = SPLIT_EN && legal && spans;
    assign fault      = !legal || (misaligned && !SPLIT_EN);
    assign lane_base  = NB2'((16'd1 << size_bytes) - 16'd1);
    assign lane_mask  = lane_base << off;
    assign wd_shifted = {{DATA_W{1'b0}}, wd_reg & value_mask} << {off, 3'b000};

    // Bit mask covering the access width, used for store data and load extension
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_value_mask
            assign value_mask[gi] = (gi < 8 * int'(size_bytes));
        end
    endgenerate

    // Funct3 legality; doubleword and LWU exist only on a 64-bit datapath
    always_comb begin
        legal = 1'b0;
        case (f3_reg)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            3'b011, 3'b110:                         legal = (DATA_W == 64);
            default:                                legal = 1'b0;
        endcase
    end

    // Load alignment: the high word is only present on the second beat of a split
    assign window_src     = (state_reg == BEAT1) ? {rdata_reg, lo_word_reg}
                                                 : {{DATA_W{1'b0}}, rdata_reg};
    assign window_shifted = window_src >> {off, 3'b000};
    assign load_raw       = window_shifted[DATA_W-1:0] & value_mask;

    // Sign/zero extension of the loaded value
    always_comb begin
        sign_bit = 1'b0;
        case (f3_reg[1:0])
            2'b00:   sign_bit = load_raw[7];
            2'b01:   sign_bit = load_raw[15];
            2'b10:   sign_bit = load_raw[31];
            default: sign_bit = load_raw[DATA_W-1];
        endcase
        load_value = load_raw;
        if (!f3_reg[2] && sign_bit) begin
            load_value = load_raw | ~value_mask;
        end
    end

    // Write port: low lanes on the BEAT0 exit edge, high lanes on the BEAT1 exit edge
    always_comb begin
        mem_we    = '0;
        mem_waddr = word_addr;
        mem_wdata = wd_shifted[DATA_W-1:0];
        if (!reset && store_reg) begin
            if (state_reg == BEAT0 && !fault) begin
                mem_we = lane_mask[NB-1:0];
            end else if (state_reg == BEAT1) begin
                mem_we    = lane_mask[NB2-1:NB];
                mem_waddr = next_word;
                mem_wdata = wd_shifted[2*DATA_W-1:DATA_W];
            end
        end
    end

    // Read address: requested word at acceptance, following word during BEAT0
    assign mem_raddr = (state_reg == IDLE) ? a[DM_ADDRESS-1:LB] : next_word;

    // Byte-lane RAM write (contents are never cleared by reset)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we[i]) begin
                mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    // Registered RAM read
    always_ff @(posedge clk) begin
        rdata_reg <= mem[mem_raddr];
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rd_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        addr_reg  <= a;
                        wd_reg    <= wd;
                        f3_reg    <= Funct3;
                        store_reg <= MemWrite && !MemRead;
                        state_reg <= BEAT0;
                    end
                end
                BEAT0: begin
                    lo_word_reg <= rdata_reg;
                    if (split) begin
                        state_reg <= BEAT1;
                    end else begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        err_reg       <= fault;
                        if (!store_reg && !fault) begin
                            rd_reg <= load_value;
                        end
                    end
                end
                BEAT1: begin
                    state_reg     <= RESP;
                    rsp_valid_reg <= 1'b1;
                    if (!store_reg) begin
                        rd_reg <= load_value;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rd        = rd_reg;
    assign rsp_valid = rsp_valid_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_datamemory_ctrl.sv
// tb_datamemory_ctrl: directed and randomized checks of datamemory_ctrl
// (default parameters) against a byte-array reference model.
module tb_datamemory_ctrl;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [2:0]  Funct3;
    logic        req_ready;
    logic [31:0] rd;
    logic        rsp_valid;
    logic        err;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mm [512];
    logic [31:0] exp_rd = 32'h0;

    datamemory_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .a(a), .wd(wd), .Funct3(Funct3), .req_ready(req_ready),
        .rd(rd), .rsp_valid(rsp_valid), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: byte-granular memory, size/alignment rules applied directly
    task automatic model_access(input bit is_load, input logic [8:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                output int lat, output logic e);
        int size;
        bit legal, mis, spans;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        mis   = (int'(addr) % size) != 0;
        spans = ((int'(addr) % 4) + size) > 4;
        lat   = (SPLIT && legal && spans) ? 3 : 2;
        e     = !legal || (mis && !SPLIT);
        if (e) return;
        if (is_load) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mm[(int'(addr) + i) % 512];
            if (!f3[2] && v[8*size-1]) for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
            exp_rd = v;
        end else begin
            for (int i = 0; i < size; i++) mm[(int'(addr) + i) % 512] = wdata[8*i +: 8];
        end
    endtask

    // One complete request/response, starting and ending on a falling edge
    task automatic txn(input bit mr, input bit mw, input logic [8:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3, input string tag);
        int   exp_lat, lat;
        logic exp_err;
        chk({tag, "_ready"}, req_ready, 1);
        model_access(mr, addr, wdata, f3, exp_lat, exp_err);
        MemRead = mr; MemWrite = mw; a = addr; wd = wdata; Funct3 = f3;
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            chk({tag, "_busy"}, req_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_rd"}, rd, exp_rd);
        $display("txn %-8s mr=%0d mw=%0d a=%03h f3=%0d wd=%08h lat=%0d err=%0b rd=%08h",
                 tag, mr, mw, addr, f3, wdata, lat, err, rd);
        @(negedge clk);
        chk({tag, "_pulse"}, rsp_valid, 0);
    endtask

    initial begin
        int          el;
        logic        ee;
        logic [7:0]  pulses, readys;
        int          op;
        logic [8:0]  ad;
        logic [2:0]  f3r;

        // Reset with a request pending: it must be ignored
        reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; a = 9'h010; wd = '0; Funct3 = 3'b010;
        repeat (3) @(negedge clk);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_rd", rd, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", req_ready, 1);
        reset = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_rsp", rsp_valid, 0);

        // Fill memory so every byte is known to the model
        for (int w = 0; w < 128; w++) txn(0, 1, 9'(w * 4), $urandom, 3'b010, "init");

        // Word/byte stores and loads with extension
        txn(0, 1, 9'h010, 32'hDEADBEEF, 3'b010, "sw10");
        txn(1, 0, 9'h010, 32'h0, 3'b010, "lw10");
        chk("lw10_lit", rd, 32'hDEADBEEF);
        txn(1, 0, 9'h010, 32'h0, 3'b000, "lb10");
        chk("lb10_lit", rd, 32'hFFFFFFEF);
        txn(1, 0, 9'h011, 32'h0, 3'b100, "lbu11");
        chk("lbu11_lit", rd, 32'h000000BE);
        txn(0, 1, 9'h012, 32'h0000007F, 3'b000, "sb12");
        txn(1, 0, 9'h010, 32'h0, 3'b010, "lw10b");
        chk("sb12_lit", rd, 32'hDE7FBEEF);
        txn(1, 0, 9'h012, 32'h0, 3'b101, "lhu12");
        txn(1, 0, 9'h011, 32'h0, 3'b001, "lh11");

        // Word crossing the top of memory
        txn(0, 1, 9'h1FE, 32'h11223344, 3'b010, "sw1fe");
        txn(1, 0, 9'h1FE, 32'h0, 3'b010, "lw1fe");
`ifdef DMEM_MISALIGN_SPLIT_EN
        chk("lw1fe_lit", rd, 32'h11223344);
`endif
        txn(1, 0, 9'h1FC, 32'h0, 3'b010, "lw1fc");
        txn(1, 0, 9'h000, 32'h0, 3'b010, "lw000");

        // Illegal Funct3 codes on a 32-bit datapath
        txn(0, 1, 9'h030, 32'h12345678, 3'b011, "sd_ill");
        txn(1, 0, 9'h030, 32'h0, 3'b110, "lwu_ill");
        txn(1, 0, 9'h030, 32'h0, 3'b111, "f3_111");
        txn(1, 0, 9'h030, 32'h0, 3'b010, "lw30");

        // Read and write together: load only
        txn(1, 1, 9'h020, 32'hFFFFFFFF, 3'b010, "rw20");
        txn(1, 0, 9'h020, 32'h0, 3'b010, "lw20");

        // Reset during BEAT0 of an aligned store: nothing written, no response
        MemWrite = 1'b1; a = 9'h080; wd = 32'hCAFEF00D; Funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0; reset = 1'b1;
        chk("ab0_rsp_b0", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0; exp_rd = 32'h0;
        chk("ab0_rsp", rsp_valid, 0);
        chk("ab0_rd", rd, 0);
        @(negedge clk);
        chk("ab0_ready", req_ready, 1);
        chk("ab0_rsp2", rsp_valid, 0);
        txn(1, 0, 9'h080, 32'h0, 3'b010, "lw80");

`ifdef DMEM_MISALIGN_SPLIT_EN
        // Reset during BEAT1 of a split store: low half stays, high half never written
        MemWrite = 1'b1; a = 9'h1FE; wd = 32'h55667788; Funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
        @(negedge clk);
        chk("ab1_rsp_b1", rsp_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; exp_rd = 32'h0;
        mm[9'h1FE] = 8'h88; mm[9'h1FF] = 8'h77;
        chk("ab1_rsp", rsp_valid, 0);
        @(negedge clk);
        chk("ab1_ready", req_ready, 1);
        chk("ab1_rsp2", rsp_valid, 0);
        txn(1, 0, 9'h1FC, 32'h0, 3'b010, "ab1_lw1fc");
        txn(1, 0, 9'h000, 32'h0, 3'b010, "ab1_lw000");
`endif

        // Back-to-back with the request held high through the busy cycles
        model_access(0, 9'h040, 32'hA5A5A5A5, 3'b010, el, ee);
        MemWrite = 1'b1; MemRead = 1'b0; a = 9'h040; wd = 32'hA5A5A5A5; Funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b1; wd = 32'h0;
        model_access(1, 9'h040, 32'h0, 3'b010, el, ee);
        pulses = '0; readys = '0;
        for (int c = 1; c <= 7; c++) begin
            pulses[c] = rsp_valid;
            readys[c] = req_ready;
            if (c == 5) begin
                chk("b2b_rd", rd, exp_rd);
                chk("b2b_rd_lit", rd, 32'hA5A5A5A5);
                MemRead = 1'b0;
            end
            @(negedge clk);
        end
        $display("txn b2b      sw+lw a=040 pulses=%08b readys=%08b rd=%08h", pulses, readys, rd);
        chk("b2b_pulses", pulses, 8'b0010_0100);
        chk("b2b_readys", readys, 8'b1100_1000);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            op  = int'($urandom_range(0, 2));
            ad  = 9'($urandom_range(0, 511));
            f3r = 3'($urandom_range(0, 7));
            txn(op != 1, op != 0, ad, $urandom, f3r, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
